mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin scheduler that shares one BIT_WIDTH-bit datapath lane, an N-to-1 operand mux feeding a downstream NFU stage, between NUM_REQ requesters. The block selects a winner with a valid/ready handshake and registers the selected word with its select code. It also drives the select that downstream mux instances reuse. Optional lock mode holds the lane for a multi-word burst.

## Interface
- NUM_REQ, 8: number of requesters, legal 2..16
- BIT_WIDTH, 16: data word width
- SEL_W, derived: clog2(NUM_REQ), not overridable

- i_clk  in  1  clock, all state rising-edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  NUM_REQ  requester k has a word
- i_req_data  in  NUM_REQ*BIT_WIDTH  word of requester k at bits [k*BIT_WIDTH +: BIT_WIDTH]
- i_lock  in  NUM_REQ  requester k requests lane hold after this word (present only with MUX_ARB_LOCK_EN)
- o_req_ready  out  NUM_REQ  one-hot or zero; word of k accepted when valid&ready
- o_valid  out  1  output word valid
- o_data  out  BIT_WIDTH  registered selected word
- o_sel  out  SEL_W  index of requester that supplied o_data
- i_ready  in  1  downstream accepts o_data when o_valid&i_ready

## Operation
- States: IDLE (o_valid=0), BUSY (o_valid=1), LOCKED (BUSY plus lock_owner held; only with macro).
- load = !o_valid || i_ready. A new word may be captured only when load=1.
- Winner: first k with i_req_valid[k]=1, searching circularly from rr_ptr upward (NUM_REQ-1 wraps to 0).
- o_req_ready[winner]=1 only when load=1 and a winner exists. Otherwise all bits are 0. o_req_ready is combinational from i_req_valid, rr_ptr, o_valid, i_ready and lock state.
- On a grant: o_data <= word, o_sel <= winner, o_valid <= 1, rr_ptr <= (winner+1) mod NUM_REQ.
- If load=1 and there is no winner: o_valid <= 0. o_data and o_sel hold their last values.
- If load=0: all registers hold. Requesters must hold valid and data until accepted.
- Transitions:
  - IDLE->BUSY on grant.
  - BUSY->IDLE when consumed with no winner.
  - BUSY->BUSY on simultaneous consume and grant, giving one word per cycle.
- rr_ptr is not updated when no grant occurs.

## Timing
- Reset (async assert, sync release): o_valid=0, o_data=0, o_sel=0, o_req_ready=0, rr_ptr=0, lock cleared. An in-flight word is dropped.
- Latency: grant cycle T gives o_valid at T+1.
- Throughput: 1 word per cycle with i_ready held high.
- Fairness: with all requesters continuously valid, o_sel cycles 0,1,…,NUM_REQ-1,0.
- While o_valid=1 and i_ready=0, o_data and o_sel are stable.

## Configuration
- MUX_ARB_LOCK_EN defined:
  - The i_lock port exists.
  - A grant to k with i_lock[k]=1 sets lock_owner=k and enters LOCKED.
  - While LOCKED, only lock_owner may win. If the owner is not valid, there is no grant and other requesters stall.
  - A grant to the owner with i_lock=0 clears the lock.
  - rr_ptr updates normally on every grant.
- MUX_ARB_LOCK_EN undefined: the i_lock port and LOCKED state are absent, giving pure round-robin.

## Structure
- Shared package mux_arb_pkg:
  - state typedef (IDLE, BUSY, LOCKED)
  - clog2 constant function for SEL_W
- Sub-module rr_pick_first: a combinational rotating-priority encoder.
  - Inputs: request vector and start pointer.
  - Outputs: found flag and index.
- The data select is an indexed part-select, so no separate mux instance is needed.

## Test plan
All scenarios use NUM_REQ=4, BIT_WIDTH=16.
- Reset mid-burst: drop i_rst_n while o_valid=1 and o_data=0x1002 -> o_valid, o_data and o_sel go to 0 immediately. After release with all requesters valid, the first o_sel=0.
- Rotation: all valid with data 0x1000+k and i_ready=1 -> o_sel 0,1,2,3,0 on consecutive cycles, o_data 0x1000..0x1003,0x1000, o_valid continuously 1.
- Backpressure: only req2 valid with 0xBEEF, then i_ready=0 for 3 cycles -> o_data holds 0xBEEF and o_req_ready=0. Req2's next word 0xCAFE is accepted in the cycle i_ready returns to 1 and appears on the following cycle.
- Wrap and pointer: last grant 3 (rr_ptr=0), then req1 and req3 valid -> grant req1, then req3; rr_ptr goes 2, then 0.
- Idle gap: requests drop with i_ready=1 -> o_valid=0 the next cycle and o_sel keeps its last value. A new request on req0 gives o_valid=1 one cycle later.
- Lock (macro on): req1 sends 3 words with i_lock=1,1,0 while req0 and req3 are valid -> o_sel 1,1,1,3,0.
  - Variant: deassert req1 valid for 2 cycles while LOCKED -> no grants and o_valid=0 until req1 returns.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin lane arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/downstream bundle for mux_rr_arbiter. i_lock exists only when MUX_ARB_LOCK_EN is defined.
interface mux_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int NUM_REQ   = 8,
  parameter int BIT_WIDTH = 16
);
  localparam int SEL_W = clog2(NUM_REQ);

  // Handshake: a requester word moves when i_req_valid[k] & o_req_ready[k] at a rising edge;
  // requesters hold valid/data until then. The output word moves when o_valid & i_ready.
  logic [NUM_REQ-1:0]           i_req_valid;
  logic [NUM_REQ*BIT_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]           o_req_ready;
  logic                         o_valid;
  logic [BIT_WIDTH-1:0]         o_data;
  logic [SEL_W-1:0]             o_sel;
  logic                         i_ready;
`ifdef MUX_ARB_LOCK_EN
  logic [NUM_REQ-1:0]           i_lock;

  modport slave  (input  i_req_valid, i_req_data, i_lock, i_ready,
                  output o_req_ready, o_valid, o_data, o_sel);
  modport master (output i_req_valid, i_req_data, i_lock, i_ready,
                  input  o_req_ready, o_valid, o_data, o_sel);
`else
  modport slave  (input  i_req_valid, i_req_data, i_ready,
                  output o_req_ready, o_valid, o_data, o_sel);
  modport master (output i_req_valid, i_req_data, i_ready,
                  input  o_req_ready, o_valid, o_data, o_sel);
`endif

endinterface

// File: rtl/mux_rr_arbiter_rr_pick_first.sv
// Rotating-priority encoder: first set bit of req searching upward from start, wrapping at N-1.
module rr_pick_first #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin : pick
    int k;
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(start) + i) % N;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin scheduler for one shared operand lane; registers the winning word and its select code.
// Define MUX_ARB_LOCK_EN to let a requester hold the lane for a multi-word burst.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int  NUM_REQ   = 8,
  parameter int  BIT_WIDTH = 16,
  localparam int SEL_W     = clog2(NUM_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  mux_rr_arbiter_if.slave  bus,
  output arb_state_t       dbg_state,
  output logic [SEL_W-1:0] dbg_rr_ptr
);

  arb_state_t           state, state_nxt;
  logic [SEL_W-1:0]     rr_ptr, win, ptr_nxt, sel_q;
  logic [BIT_WIDTH-1:0] data_q;
  logic [NUM_REQ-1:0]   req_eff;
  logic                 found, load, grant;

`ifdef MUX_ARB_LOCK_EN
  logic             lock_active, lock_active_nxt;
  logic [SEL_W-1:0] lock_owner, lock_owner_nxt;

  // While locked only the owner is eligible; everyone else stalls even if the owner is idle.
  always_comb begin
    req_eff = bus.i_req_valid;
    if (lock_active) req_eff = bus.i_req_valid & (NUM_REQ'(1) << lock_owner);
  end
`else
  assign req_eff = bus.i_req_valid;
`endif

  rr_pick_first #(.N(NUM_REQ), .W(SEL_W)) u_pick (
    .req   (req_eff),
    .start (rr_ptr),
    .found (found),
    .idx   (win)
  );

  assign load    = (state == ST_IDLE) || bus.i_ready;
  assign grant   = i_rst_n && load && found;
  assign ptr_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + SEL_W'(1);

  assign bus.o_req_ready = grant ? (NUM_REQ'(1) << win) : '0;
  assign bus.o_valid     = (state != ST_IDLE);
  assign bus.o_data      = data_q;
  assign bus.o_sel       = sel_q;
  assign dbg_state       = state;
  assign dbg_rr_ptr      = rr_ptr;

  always_comb begin
    state_nxt = state;
`ifdef MUX_ARB_LOCK_EN
    lock_active_nxt = lock_active;
    lock_owner_nxt  = lock_owner;
`endif
    if (load) begin
      if (grant) begin
        state_nxt = ST_BUSY;
`ifdef MUX_ARB_LOCK_EN
        lock_active_nxt = bus.i_lock[win];
        if (bus.i_lock[win]) begin
          lock_owner_nxt = win;
          state_nxt      = ST_LOCKED;
        end
`endif
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
`ifdef MUX_ARB_LOCK_EN
      lock_active <= 1'b0;
      lock_owner  <= '0;
`endif
    end else begin
      state <= state_nxt;
`ifdef MUX_ARB_LOCK_EN
      lock_active <= lock_active_nxt;
      lock_owner  <= lock_owner_nxt;
`endif
    end
  end

  // Select and word only move on a grant, so they stay put through idle gaps and backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      sel_q  <= '0;
      rr_ptr <= '0;
    end else if (grant) begin
      data_q <= bus.i_req_data[int'(win)*BIT_WIDTH +: BIT_WIDTH];
      sel_q  <= win;
      rr_ptr <= ptr_nxt;
    end
  end

endmodule
